// File: rtl/sub_32_seq.sv
// Sequential multi-slice subtractor: D = A - B - BIN, one SLICE-bit group per clock,
// LSB slice first, borrow rippled through a flop. Buses use [0:WIDTH-1] (bit 0 = MSB).
module sub_32_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [0:WIDTH-1] a,
   input  logic [0:WIDTH-1] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [0:WIDTH-1] d,
   output logic             bout,
   output logic             ovf
);

   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [0:WIDTH-1]   a_q, a_d, b_q, b_d, d_q, d_d;
   logic               borrow_q, borrow_d;
   logic               bout_q, bout_d, ovf_q, ovf_d;
   logic               busy_q, busy_d, done_q, done_d;

   logic [SLICE-1:0]   a_s, b_s;
   logic [SLICE:0]     sum;

   // Next-state, slice datapath and result updates
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      borrow_d = borrow_q;
      d_d      = d_q;
      bout_d   = bout_q;
      ovf_d    = ovf_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      a_s      = '0;
      b_s      = '0;

      for (int unsigned k = 0; k < NSLICE; k++) begin
         if (cnt_q == CNT_W'(k)) begin
            a_s = a_q[WIDTH-SLICE*(k+1) +: SLICE];
            b_s = b_q[WIDTH-SLICE*(k+1) +: SLICE];
         end
      end
      // a - b - borrow computed as a + ~b + ~borrow; no carry out means a borrow
      sum = {1'b0, a_s} + {1'b0, ~b_s} + {{SLICE{1'b0}}, ~borrow_q};

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d      = a;
               b_d      = b;
               borrow_d = bin;
               cnt_d    = '0;
               busy_d   = 1'b1;
               state_d  = RUN;
            end else begin
               state_d  = IDLE;
            end
         end
         RUN: begin
            busy_d   = 1'b1;
            borrow_d = ~sum[SLICE];
            cnt_d    = cnt_q + CNT_W'(1);
            for (int unsigned k = 0; k < NSLICE; k++) begin
               if (cnt_q == CNT_W'(k)) begin
                  d_d[WIDTH-SLICE*(k+1) +: SLICE] = sum[SLICE-1:0];
               end
            end
            if (cnt_q == CNT_W'(NSLICE-1)) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               bout_d  = ~sum[SLICE];
               ovf_d   = (a_q[0] ^ b_q[0]) & (d_d[0] ^ a_q[0]);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         borrow_q <= 1'b0;
         d_q      <= '0;
         bout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         borrow_q <= borrow_d;
         d_q      <= d_d;
         bout_q   <= bout_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign d    = d_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_sub_32_seq.sv
// Directed and random self-checking bench for sub_32_seq (default 32/8 configuration).
module tb_sub_32_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [0:31] a, b, d;
   logic        bin, busy, done, bout, ovf;

   int checks = 0;
   int errors = 0;
   int lat, bc;

   sub_32_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .d     (d),
      .bout  (bout),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   // Drives one request from the current (post-edge) point and waits, bounded, for done.
   task automatic do_op(input logic [31:0] oa, input logic [31:0] ob, input logic obin,
                        output int olat, output int obusy);
      a = oa; b = ob; bin = obin; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      olat = 1; obusy = 0;
      while (done !== 1'b1 && olat < 20) begin
         if (busy === 1'b1) obusy++;
         @(posedge clk); #1;
         olat++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
      checks++; if ({d, bout, ovf} !== 34'h0) begin errors++; $display("FAIL rst_result: got d=%h bout=%b ovf=%b expected zeros", d, bout, ovf); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      do_op(32'd5, 32'd3, 1'b0, lat, bc);
      checks++; if (lat !== 5) begin errors++; $display("FAIL t1_latency: got %0d expected 5", lat); end
      checks++; if (bc !== 4) begin errors++; $display("FAIL t1_busy_cycles: got %0d expected 4", bc); end
      checks++; if (d !== 32'h00000002) begin errors++; $display("FAIL t1_d: got %h expected 00000002", d); end
      checks++; if ({bout, ovf} !== 2'b00) begin errors++; $display("FAIL t1_flags: got bout=%b ovf=%b expected 0 0", bout, ovf); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL t1_done_pulse: got %b expected 0", done); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (d !== 32'h00000002) begin errors++; $display("FAIL t1_hold: got %h expected 00000002", d); end
   endtask

   task automatic test_borrow_ripple();
      do_op(32'h00000000, 32'h00000001, 1'b0, lat, bc);
      checks++; if (d !== 32'hFFFFFFFF || bout !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL t2_ripple: got d=%h bout=%b ovf=%b expected FFFFFFFF 1 0", d, bout, ovf); end
      do_op(32'h00000100, 32'h00000001, 1'b1, lat, bc);
      checks++; if (d !== 32'h000000FE || bout !== 1'b0) begin errors++; $display("FAIL t4_bin: got d=%h bout=%b expected 000000FE 0", d, bout); end
      do_op(32'h12345678, 32'h12345678, 1'b0, lat, bc);
      checks++; if (d !== 32'h0 || bout !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL equal_ops: got d=%h bout=%b ovf=%b expected 00000000 0 0", d, bout, ovf); end
      do_op(32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, lat, bc);
      checks++; if (d !== 32'hFFFFFFFF || bout !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL equal_bin: got d=%h bout=%b ovf=%b expected FFFFFFFF 1 0", d, bout, ovf); end
      @(posedge clk); #1;
   endtask

   task automatic test_overflow();
      do_op(32'h80000000, 32'h00000001, 1'b0, lat, bc);
      checks++; if (d !== 32'h7FFFFFFF || bout !== 1'b0 || ovf !== 1'b1) begin errors++; $display("FAIL t3_neg_ovf: got d=%h bout=%b ovf=%b expected 7FFFFFFF 0 1", d, bout, ovf); end
      do_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, lat, bc);
      checks++; if (d !== 32'h80000000 || bout !== 1'b1 || ovf !== 1'b1) begin errors++; $display("FAIL t3_pos_ovf: got d=%h bout=%b ovf=%b expected 80000000 1 1", d, bout, ovf); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int waited;
      a = 32'd10; b = 32'd3; bin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      a = 32'hFFFFFFFF; b = 32'h00000001; bin = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      waited = 0;
      while (done !== 1'b1 && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      checks++; if (waited !== 2) begin errors++; $display("FAIL t5_ignored_latency: got %0d expected 2", waited); end
      checks++; if (d !== 32'h00000007 || bout !== 1'b0) begin errors++; $display("FAIL t5_ignored_result: got d=%h bout=%b expected 00000007 0", d, bout); end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL t5_no_queue: got busy=%b done=%b expected 0 0", busy, done); end
      do_op(32'd100, 32'd1, 1'b0, lat, bc);
      checks++; if (lat !== 5 || d !== 32'd99) begin errors++; $display("FAIL t5_first: got lat=%0d d=%h expected 5 00000063", lat, d); end
      do_op(32'd20, 32'd5, 1'b1, lat, bc);
      checks++; if (lat !== 5 || d !== 32'd14) begin errors++; $display("FAIL t5_b2b: got lat=%0d d=%h expected 5 0000000E", lat, d); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_abort();
      int seen;
      a = 32'hFFFFFFFF; b = 32'h00000000; bin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL t6_abort_ctrl: got busy=%b done=%b expected 0 0", busy, done); end
      checks++; if ({d, bout, ovf} !== 34'h0) begin errors++; $display("FAIL t6_abort_result: got d=%h bout=%b ovf=%b expected zeros", d, bout, ovf); end
      rst_n = 1'b1;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL t6_no_done: got %0d pulses expected 0", seen); end
   endtask

   task automatic test_random();
      logic [31:0] ra, rb, ed;
      logic        rbin, eovf;
      logic [32:0] r;
      for (int i = 0; i < 1000; i++) begin
         ra   = $urandom();
         rb   = (i % 8 == 0) ? ra : $urandom();
         rbin = 1'($urandom_range(1, 0));
         r    = {1'b0, ra} - {1'b0, rb} - 33'(rbin);
         ed   = r[31:0];
         eovf = (ra[31] ^ rb[31]) & (ed[31] ^ ra[31]);
         do_op(ra, rb, rbin, lat, bc);
         checks++;
         if (lat !== 5 || d !== ed || bout !== r[32] || ovf !== eovf) begin
            errors++;
            $display("FAIL rand_%0d: a=%h b=%h bin=%b got lat=%0d d=%h bout=%b ovf=%b expected 5 %h %b %b",
                     i, ra, rb, rbin, lat, d, bout, ovf, ed, r[32], eovf);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_borrow_ripple();
      test_overflow();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
